fb_scanout_arbiter: RTL and testbench
=====================================

# fb_scanout_arbiter

Shares one single-port framebuffer RAM between the video scan-out path and a host write port. It prefetches the 160×120 RGB332 framebuffer line by line into a 4-entry FIFO that feeds the per-pixel colour path. It guarantees the display never starves while a host keeps streaming writes. It sits on the 250 MHz data clock between `video_sync` (line and pixel strobes) and the `coloroutput` inputs.

## Interface
- FB_W, 160: framebuffer columns (each drives 4 screen pixels).
- FB_H, 120: framebuffer rows (each drives 4 screen lines).
- ADDR_W, 15: RAM address width; must hold FB_W*FB_H-1.
- DATA_W, 8: pixel width (RGB332).

Ports:
- clk  in  1  data clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- line_start  in  1  one-cycle pulse at start of horizontal blanking preceding each active line.
- fb_row  in  7  framebuffer row of the upcoming line; sampled on line_start.
- pix_req  in  1  one-cycle pop strobe; display consumes one framebuffer pixel.
- pix_data  out  DATA_W  FIFO head (first-word-fall-through); 0 when FIFO empty.
- underflow  out  1  sticky: pix_req seen with FIFO empty; cleared only by reset.
- host_valid  in  1  host write request.
- host_ready  out  1  host owns RAM this cycle; write accepted when host_valid & host_ready.
- host_addr  in  ADDR_W  host write address.
- host_data  in  DATA_W  host write data.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data (= host_data).
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after a read address.

## Operation
- States: IDLE (after reset, no line known), FLUSH (one cycle after line_start), LINE (fetching/holding a line).
- Transitions:
  - IDLE –line_start→ FLUSH.
  - FLUSH → LINE, or FLUSH again if line_start repeats.
  - LINE –line_start→ FLUSH.
- On line_start, in any state:
  - latch base = fb_row*160, computed as (fb_row<<7)+(fb_row<<5);
  - col ← 0;
  - FIFO cleared;
  - a read in flight is marked discard, and its returning data is not pushed.
- credits = FIFO level + read-in-flight (0..4).
- Arbitration in LINE, in priority order:
  - urgent display read if credits<2 and col<FB_W;
  - else host, if host_valid;
  - else display read if credits<4 and col<FB_W;
  - else host.
- In IDLE and FLUSH the host always owns the RAM.
- Display read:
  - mem_addr = base+col, mem_we=0, host_ready=0, col+1;
  - next cycle mem_rdata is pushed into the FIFO.
- Host cycle:
  - host_ready=1 regardless of host_valid; mem_addr=host_addr;
  - mem_we = host_valid & (host_addr < FB_W*FB_H);
  - out-of-range writes are accepted and dropped.
- col saturates at FB_W. The rest of the line is host-only until the next line_start.
- Simultaneous push and pop: level unchanged, head advances.
- Pop on empty: no level change, and underflow←1.
- The FIFO never overflows: credits are capped at 4.

## Timing
- Reset (rst low), asynchronous and effective immediately:
  - state=IDLE, FIFO empty, col=0, base=0;
  - pix_data=0, underflow=0, mem_we=0, mem_addr=0, host_ready=0.
  - host_ready and mem_we are forced low while rst is low.
- mem_addr, mem_we and host_ready are combinational from the registered state, credits and col, plus host_valid (mem_we only).
- Read latency: address in cycle N → FIFO push at end of cycle N+1 → visible on pix_data in cycle N+2.
- First pixel of a line is available on pix_data 3 cycles after line_start (FLUSH, read, push).
- Host worst-case wait in LINE: 2 consecutive cycles while credits<2. Display pixel period is 40 clk, so sustained host throughput is ≥ 38/40 cycles.
- Reset mid-line: all state discarded; the next line fetch needs a fresh line_start.

## Test plan
- Reset then line_start with fb_row=3:
  - reads issued at addresses 480,481,482,483;
  - FIFO fills to 4 and reads stop;
  - pix_data=RAM[480] at cycle +3.
- Host streams host_valid=1 throughout a line with pix_req every 40 cycles:
  - all 160 reads are issued, in order 480..639;
  - underflow stays 0;
  - host accepted on every non-display cycle.
- Host write to address 19200:
  - host_ready=1 and mem_we=0;
  - the RAM is unchanged.
- line_start while a read is in flight and the FIFO holds 3:
  - FIFO empties;
  - the returning data is discarded;
  - the first new read goes to the new base.
- pix_req issued 2 cycles after line_start:
  - underflow=1 and pix_data=0;
  - underflow stays set until reset.
- Assert rst mid-line:
  - outputs go to their reset values asynchronously;
  - no read issues after release until line_start.

Source files
------------

// File: rtl/fb_scanout_arbiter.sv
// Single-port framebuffer arbiter: prefetches one scan line into a 4-entry FWFT FIFO
// for the pixel path and hands every other RAM cycle to the host write port.
module fb_scanout_arbiter #(
  parameter int unsigned FB_W   = 160,
  parameter int unsigned FB_H   = 120,
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_start,
  input  logic [6:0]        fb_row,
  input  logic              pix_req,
  output logic [DATA_W-1:0] pix_data,
  output logic              underflow,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned       COL_W   = $clog2(FB_W + 1);
  localparam logic [COL_W-1:0]  COL_END = COL_W'(FB_W);
  localparam logic [ADDR_W-1:0] NPIX    = ADDR_W'(FB_W * FB_H);

  typedef enum logic [1:0] {StIdle, StFlush, StLine} state_t;

  state_t              r_state;
  state_t              w_state_d;
  logic [ADDR_W-1:0]   r_base;
  logic [COL_W-1:0]    r_col;
  logic [DATA_W-1:0]   r_fifo [4];
  logic [1:0]          r_rd_ptr;
  logic [1:0]          r_wr_ptr;
  logic [2:0]          r_level;
  logic                r_inflight;
  logic                r_discard;
  logic                r_underflow;

  logic [2:0]          w_credits;
  logic                w_col_ok;
  logic                w_rd;
  logic                w_push;
  logic                w_pop;
  logic [ADDR_W-1:0]   w_base_d;

  // fb_row * 160 as two shifted copies
  assign w_base_d  = ADDR_W'({fb_row, 7'b0}) + ADDR_W'({fb_row, 5'b0});

  assign w_credits = r_level + {2'b0, r_inflight};
  assign w_col_ok  = (r_col < COL_END);
  assign w_rd      = (r_state == StLine) && w_col_ok &&
                     ((w_credits < 3'd2) || (!host_valid && (w_credits < 3'd4)));

  assign w_push    = r_inflight && !r_discard;
  assign w_pop     = pix_req && (r_level != 3'd0);

  assign host_ready = rst && !w_rd;
  assign mem_we     = rst && !w_rd && host_valid && (host_addr < NPIX);
  assign mem_addr   = !rst ? '0 : (w_rd ? r_base + ADDR_W'(r_col) : host_addr);
  assign mem_wdata  = host_data;

  assign pix_data   = (r_level != 3'd0) ? r_fifo[r_rd_ptr] : '0;
  assign underflow  = r_underflow;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (line_start) w_state_d = StFlush;
      StFlush: w_state_d = line_start ? StFlush : StLine;
      StLine:  if (line_start) w_state_d = StFlush;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_col       <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_level     <= '0;
      r_inflight  <= 1'b0;
      r_discard   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_inflight <= w_rd;
      if (pix_req && (r_level == 3'd0)) r_underflow <= 1'b1;
      if (line_start) begin
        // Any read issued now returns after the FIFO has been cleared; drop it.
        r_base    <= w_base_d;
        r_col     <= '0;
        r_rd_ptr  <= '0;
        r_wr_ptr  <= '0;
        r_level   <= '0;
        r_discard <= 1'b1;
      end else begin
        r_discard <= 1'b0;
        if (w_rd)   r_col    <= r_col + COL_W'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
        if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
        r_level <= r_level + {2'b0, w_push} - {2'b0, w_pop};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !line_start) r_fifo[r_wr_ptr] <= mem_rdata;
  end

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Randomized bench for fb_scanout_arbiter: a queue-based line-prefetch model predicts every
// RAM cycle and FIFO output; directed steps hit line start, flush, underflow and reset cases.
module tb_fb_scanout_arbiter;

  localparam int FBW  = 160;
  localparam int NPIX = 19200;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [6:0]  fb_row;
  logic        pix_req;
  logic [7:0]  pix_data;
  logic        underflow;
  logic        host_valid;
  logic        host_ready;
  logic [14:0] host_addr;
  logic [7:0]  host_data;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  fb_scanout_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .fb_row     (fb_row),
    .pix_req    (pix_req),
    .pix_data   (pix_data),
    .underflow  (underflow),
    .host_valid (host_valid),
    .host_ready (host_ready),
    .host_addr  (host_addr),
    .host_data  (host_data),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Physical single-port RAM with one-cycle read latency.
  logic [7:0] ram [0:32767];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Reference model: framebuffer contents, line cursor and the pixel queue.
  logic [7:0] m_ram [0:32767];
  logic [7:0] m_q [$];
  int         m_phase;     // 0 no line, 1 flush cycle, 2 line active
  int         m_base;
  int         m_col;
  int         m_inflight;
  int         m_discard;
  logic [7:0] m_inflight_val;
  int         m_uf;

  int n_checks;
  int n_fail;
  int n_reads;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_q.delete();
    m_phase        = 0;
    m_base         = 0;
    m_col          = 0;
    m_inflight     = 0;
    m_discard      = 0;
    m_inflight_val = 8'h00;
    m_uf           = 0;
  endtask

  // Display read this cycle? Urgent below 2 credits, opportunistic when the host is quiet.
  function automatic bit m_display_read();
    int credits;
    credits = m_q.size() + m_inflight;
    return (m_phase == 2) && (m_col < FBW) &&
           ((credits < 2) || (!host_valid && credits < 4));
  endfunction

  // Check this cycle's outputs at the falling edge, then advance the model at the rising edge.
  task automatic tick();
    bit         rd;
    bit         exp_we;
    int         exp_addr;
    int         exp_pix;
    bit         push;
    logic [7:0] pv;
    logic [7:0] nv;
    @(negedge clk);
    rd       = m_display_read();
    exp_addr = rd ? (m_base + m_col) : int'(host_addr);
    exp_we   = !rd && host_valid && (int'(host_addr) < NPIX);
    exp_pix  = (m_q.size() > 0) ? int'(m_q[0]) : 0;
    chk("mem_addr",   32'(mem_addr),   exp_addr);
    chk("mem_we",     32'(mem_we),     32'(exp_we));
    chk("host_ready", 32'(host_ready), 32'(!rd));
    chk("pix_data",   32'(pix_data),   exp_pix);
    chk("underflow",  32'(underflow),  m_uf);
    if (host_ready === 1'b0) n_reads++;
    @(posedge clk);
    if (pix_req && m_q.size() == 0) m_uf = 1;
    push = (m_inflight != 0) && (m_discard == 0);
    pv   = m_inflight_val;
    if (exp_we) m_ram[host_addr] = host_data;
    nv = rd ? m_ram[15'(m_base + m_col)] : 8'h00;
    if (line_start) begin
      m_q.delete();
      m_base    = int'(fb_row) * 160;
      m_col     = 0;
      m_phase   = 1;
      m_discard = 1;
    end else begin
      if (pix_req && m_q.size() > 0) void'(m_q.pop_front());
      if (push) m_q.push_back(pv);
      m_discard = 0;
      if (rd) m_col++;
      if (m_phase == 1) m_phase = 2;
    end
    m_inflight     = rd ? 1 : 0;
    m_inflight_val = nv;
    #1;
  endtask

  task automatic rand_host(input int pct_valid);
    host_valid = ($urandom_range(0, 99) < pct_valid);
    if ($urandom_range(0, 15) == 0) host_addr = 15'($urandom_range(NPIX, 32767));
    else                            host_addr = 15'($urandom_range(0, NPIX - 1));
    host_data = 8'($urandom);
  endtask

  initial begin
    int bad;
    n_checks   = 0;
    n_fail     = 0;
    n_reads    = 0;
    rst        = 1'b0;
    line_start = 1'b0;
    fb_row     = '0;
    pix_req    = 1'b0;
    host_valid = 1'b1;
    host_addr  = 15'd1234;
    host_data  = 8'h5a;
    m_reset();

    // Reset values, with host_valid high to show the handshake is forced low.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_addr",   32'(mem_addr),   0);
    chk("rst_mem_we",     32'(mem_we),     0);
    chk("rst_host_ready", 32'(host_ready), 0);
    chk("rst_pix_data",   32'(pix_data),   0);
    chk("rst_underflow",  32'(underflow),  0);
    rst = 1'b1;

    // Fill the whole framebuffer through the host port while no line is known.
    for (int i = 0; i < NPIX; i++) begin
      host_valid = 1'b1;
      host_addr  = 15'(i);
      host_data  = 8'($urandom);
      tick();
    end
    repeat (10) begin
      rand_host(50);
      tick();
    end

    // Line fetch for row 3 with a quiet host: four reads from 480, then the FIFO is full.
    host_valid = 1'b0;
    fb_row     = 7'd3;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    n_reads    = 0;
    repeat (3) tick();
    chk("first_pixel", 32'(pix_data), 32'(m_ram[480]));
    repeat (10) tick();
    chk("fill_reads", n_reads, 4);

    // Host streams all line long, display pops every 40 cycles.
    fb_row     = 7'd3;
    line_start = 1'b1;
    rand_host(100);
    tick();
    line_start = 1'b0;
    n_reads    = 0;
    for (int c = 1; c <= 6500; c++) begin
      rand_host(100);
      pix_req = ((c % 40) == 0) && (c <= 6400);
      tick();
    end
    pix_req = 1'b0;
    chk("stream_reads",     n_reads,           160);
    chk("stream_underflow", 32'(underflow),    0);

    // Out-of-range host write is accepted but never reaches the RAM.
    host_valid = 1'b1;
    host_addr  = 15'd19200;
    host_data  = 8'hff;
    #1;
    chk("oor_ready", 32'(host_ready), 1);
    chk("oor_we",    32'(mem_we),     0);
    tick();

    // line_start with three pixels queued and one read in flight.
    host_valid = 1'b0;
    host_addr  = '0;
    fb_row     = 7'd5;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (10) tick();
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    #1;
    chk("refill_read", 32'(host_ready), 0);
    tick();
    fb_row     = 7'd7;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    chk("flush_empty", 32'(pix_data), 0);
    tick();
    chk("discarded", 32'(pix_data), 0);
    chk("new_base",  32'(mem_addr), 1120);
    repeat (6) tick();

    // Pop two cycles after line_start: nothing fetched yet.
    fb_row     = 7'd9;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    tick();
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    chk("uf_set",   32'(underflow), 1);
    chk("uf_pixel", 32'(pix_data),  0);
    repeat (20) begin
      rand_host(50);
      tick();
    end
    chk("uf_sticky", 32'(underflow), 1);

    // Asynchronous reset in the middle of a line.
    fb_row     = 7'd11;
    host_valid = 1'b0;
    line_start = 1'b1;
    tick();
    line_start = 1'b0;
    repeat (3) tick();
    host_valid = 1'b1;
    host_addr  = 15'd77;
    rst        = 1'b0;
    #1;
    chk("arst_mem_addr",   32'(mem_addr),   0);
    chk("arst_mem_we",     32'(mem_we),     0);
    chk("arst_host_ready", 32'(host_ready), 0);
    chk("arst_pix_data",   32'(pix_data),   0);
    chk("arst_underflow",  32'(underflow),  0);
    m_reset();
    @(posedge clk);
    #1;
    chk("arst_hold_ready", 32'(host_ready), 0);
    rst     = 1'b1;
    n_reads = 0;
    repeat (20) begin
      rand_host(60);
      tick();
    end
    chk("post_rst_reads", n_reads, 0);

    bad = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (ram[i] !== m_ram[i]) bad++;
    end
    chk("ram_contents", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
